// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit instruction
// words, writes them to consecutive instruction-memory addresses from 0, and
// raises cu_enable once the program is resident.
// Optional checksum trailer byte: define IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [31:0]       wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cu_enable
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
`ifdef IMEM_LOADER_CHKSUM_EN
      CHK   = 3'd3,
`endif
      DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_W   = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       asm_q, asm_d;
   // last committed address/data, so the write bus is stable between strobes
   logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
   logic [31:0]       data_hold_q, data_hold_d;
`ifdef IMEM_LOADER_CHKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              err_q, err_d;
`endif

   logic [ADDR_W:0]   len_clamp;
   logic              last_word;

   assign len_clamp = (load_len > DEPTH_L) ? DEPTH_L : load_len;
   assign last_word = ({1'b0, word_cnt_q} == (len_q - ONE_L));

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         word_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         asm_q       <= '0;
         addr_hold_q <= '0;
         data_hold_q <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
         sum_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         word_cnt_q  <= word_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         addr_hold_q <= addr_hold_d;
         data_hold_q <= data_hold_d;
`ifdef IMEM_LOADER_CHKSUM_EN
         sum_q       <= sum_d;
         err_q       <= err_d;
`endif
      end
   end

   // next-state, datapath updates and handshake/strobe outputs
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      word_cnt_d  = word_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
      addr_hold_d = addr_hold_q;
      data_hold_d = data_hold_q;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_d       = sum_q;
      err_d       = err_q;
`endif
      in_ready    = 1'b0;
      wr_en       = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (load_start) begin
               len_d      = len_clamp;
               word_cnt_d = '0;
               byte_cnt_d = '0;
               asm_d      = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
               sum_d      = '0;
               err_d      = 1'b0;
`endif
               state_d    = (len_clamp == '0) ? DONE : RECV;
            end
         end
         RECV: begin
            in_ready = 1'b1;
            if (in_valid) begin
               for (int i = 0; i < 4; i++) begin
                  if (byte_cnt_q == 2'(i)) asm_d[i*8 +: 8] = in_data;
               end
`ifdef IMEM_LOADER_CHKSUM_EN
               sum_d = sum_q + in_data;
`endif
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            wr_en       = 1'b1;
            addr_hold_d = word_cnt_q;
            data_hold_d = asm_q;
            if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
               state_d = CHK;
`else
               state_d = DONE;
`endif
            end else begin
               word_cnt_d = word_cnt_q + ONE_W;
               state_d    = RECV;
            end
         end
`ifdef IMEM_LOADER_CHKSUM_EN
         CHK: begin
            in_ready = 1'b1;
            if (in_valid) begin
               err_d   = ((sum_q + in_data) != 8'd0);
               state_d = DONE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // write bus shows the live word during WRITE, the last committed one otherwise
   assign wr_addr   = {{(32-ADDR_W){1'b0}}, (wr_en ? word_cnt_q : addr_hold_q)};
   assign wr_data   = wr_en ? asm_q : data_hold_q;
   assign done      = (state_q == DONE);
`ifdef IMEM_LOADER_CHKSUM_EN
   assign busy      = (state_q == RECV) || (state_q == WRITE) || (state_q == CHK);
   assign err       = err_q;
`else
   assign busy      = (state_q == RECV) || (state_q == WRITE);
   assign err       = 1'b0;
`endif
   assign cu_enable = done & ~err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [5:0]  load_len;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready, wr_en, busy, done, err, cu_enable;
   logic [31:0] wr_addr, wr_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int wr_cnt = 0;
   logic [63:0] exp_q[$];
   int          wr_cyc[$];

   imem_loader #(.ADDR_W(5), .DEPTH(32)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .done(done), .err(err), .cu_enable(cu_enable)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write strobe pops and compares the expected word
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_cnt++;
         wr_cyc.push_back(cyc);
         chk("in_ready_during_write", {31'd0, in_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", wr_addr, 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e[63:32]);
            chk("wr_data", wr_data, e[31:0]);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // called at a negedge; returns at the negedge after the byte was taken
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input int addr, input logic [31:0] w, input bit gaps);
      exp_q.push_back({32'(addr), w});
      for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], gaps);
   endtask

   task automatic start(input logic [5:0] len);
      @(negedge clk);
      load_start = 1'b1;
      load_len   = len;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int base;
      rst = 1'b0; load_start = 1'b0; load_len = '0; in_valid = 1'b1; in_data = 8'h5A;

      // reset held two cycles with in_valid asserted
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_cu_enable", {31'd0, cu_enable}, 32'd0);
      chk("rst_wr_addr", wr_addr, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_no_write", 32'(wr_cnt), 32'd0);
      rst = 1'b1; in_valid = 1'b0;

      // single word
      start(6'd1);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      send_word(0, 32'h12345678, 1'b0);
      wait_done("t1_done");
      chk("t1_cu_enable", {31'd0, cu_enable}, 32'd1);
      chk("t1_busy_low", {31'd0, busy}, 32'd0);
      chk("t1_writes", 32'(wr_cnt), 32'd1);
      chk("t1_hold_addr", wr_addr, 32'd0);
      chk("t1_hold_data", wr_data, 32'h12345678);

      // continuous stream, 3 words
      wr_cyc.delete(); base = wr_cnt;
      start(6'd3);
      chk("t2_done_cleared", {31'd0, done}, 32'd0);
      for (int i = 0; i < 3; i++) send_word(i, 32'hA0B0C0D0 + 32'(i * 32'h01010101), 1'b0);
      wait_done("t2_done");
      chk("t2_writes", 32'(wr_cnt - base), 32'd3);
      if (wr_cyc.size() == 3) begin
         chk("t2_spacing01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
         chk("t2_spacing12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd5);
      end else chk("t2_pulse_count", 32'(wr_cyc.size()), 32'd3);

      // random valid gaps
      base = wr_cnt;
      start(6'd4);
      for (int i = 0; i < 4; i++) send_word(i, $urandom(), 1'b1);
      wait_done("t3_done");
      chk("t3_writes", 32'(wr_cnt - base), 32'd4);

      // zero length: done next cycle, no write
      base = wr_cnt;
      start(6'd0);
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("t4_no_write", 32'(wr_cnt - base), 32'd0);

      // length 40 clamps to 32; a mid-load start is ignored
      base = wr_cnt;
      start(6'd40);
      for (int i = 0; i < 32; i++) begin
         if (i == 10) begin
            load_start = 1'b1; load_len = 6'd1;
            @(negedge clk);
            load_start = 1'b0;
            chk("t5_ignore_busy", {31'd0, busy}, 32'd1);
         end
         send_word(i, {8'(i), 8'hC3, 8'(~i), 8'h3C}, 1'b0);
      end
      wait_done("t5_done");
      chk("t5_writes", 32'(wr_cnt - base), 32'd32);
      chk("t5_last_addr", wr_addr, 32'd31);
      chk("t5_cu_enable", {31'd0, cu_enable}, 32'd1);

      // reset after 6 bytes, then a clean restart at address 0
      start(6'd2);
      send_word(0, 32'h11223344, 1'b0);
      send_byte(8'hEE, 1'b0);
      send_byte(8'hFF, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_done", {31'd0, done}, 32'd0);
      chk("t6_wr_addr", wr_addr, 32'd0);
      chk("t6_wr_data", wr_data, 32'd0);
      base = wr_cnt;
      start(6'd1);
      send_word(0, 32'hDDCCBBAA, 1'b0);
      wait_done("t6_restart_done");
      chk("t6_restart_writes", 32'(wr_cnt - base), 32'd1);

`ifdef IMEM_LOADER_CHKSUM_EN
      start(6'd1);
      send_word(0, 32'h04030201, 1'b0);
      repeat (2) @(negedge clk);
      chk("c1_not_done_before_chk", {31'd0, done}, 32'd0);
      send_byte(8'hF6, 1'b0);
      chk("c1_done", {31'd0, done}, 32'd1);
      chk("c1_err", {31'd0, err}, 32'd0);
      chk("c1_cu_enable", {31'd0, cu_enable}, 32'd1);
      start(6'd1);
      chk("c2_err_cleared", {31'd0, err}, 32'd0);
      send_word(0, 32'h04030201, 1'b0);
      send_byte(8'hF5, 1'b0);
      chk("c2_done", {31'd0, done}, 32'd1);
      chk("c2_err", {31'd0, err}, 32'd1);
      chk("c2_cu_enable", {31'd0, cu_enable}, 32'd0);
`else
      chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader for the SIMD core, on the write side of the instruction memory the control unit fetches from. It accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes them to consecutive word addresses starting at 0. When the load is complete it raises `cu_enable`, which drives the control unit's `enable`, so the program counter only starts fetching after the program is resident.

## Interface
- `ADDR_W`, 5: instruction-memory word-address width.
- `DEPTH`, 32: maximum words per load (≤ 2^ADDR_W).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `load_start`  in  1  single-cycle request to begin a load; honoured only when not `busy`.
- `load_len`  in  ADDR_W+1  word count, sampled with `load_start`; values > `DEPTH` clamp to `DEPTH`.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  32  word address, zero-extended from the internal ADDR_W counter.
- `wr_data`  out  32  assembled instruction word.
- `busy`  out  1  a load is in progress.
- `done`  out  1  level; load finished; held until the next accepted `load_start` or reset.
- `err`  out  1  checksum mismatch (see Configuration); constant 0 when the feature is compiled out.
- `cu_enable`  out  1  `done & ~err`.

## Operation
- States: IDLE, RECV, WRITE, CHK (checksum build only), DONE.
- Reset (`rst`=0 at an edge) puts every output at 0 and the FSM in IDLE, and clears all counters and the assembly register. Reset mid-load discards the partial word and any remaining count.
- IDLE/DONE: on `load_start`:
  - latch the clamped length, clear `word_cnt`, `byte_cnt` and the checksum, and clear `done`/`err`;
  - go to DONE directly if the length is 0, otherwise go to RECV.
- RECV: `in_ready`=1. Each transfer (`in_valid & in_ready`) writes `in_data` into byte lane `byte_cnt` (lane 0 = bits 7:0) and increments `byte_cnt` mod 4. The 4th byte moves the FSM to WRITE.
- WRITE: `in_ready`=0, `wr_en`=1, `wr_addr`=`word_cnt`, `wr_data`=assembled word. Next state:
  - if `word_cnt` = length−1: go to DONE, or to CHK when the checksum is built in;
  - otherwise increment `word_cnt` and return to RECV.
- DONE: `done`=1 and `busy`=0.
- `busy`=1 in RECV, WRITE and CHK.
- `load_start` while `busy` is ignored.
- `in_ready` is 0 outside RECV/CHK. Bytes offered then are not consumed.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.

## Timing
- `load_start` sampled at edge N → `busy`=1 and `in_ready`=1 from N+1. The first byte can be accepted at edge N+1.
- 4th byte of a word accepted at edge K → `wr_en` high from K until edge K+1, when memory captures the word. `in_ready` returns at K+1.
- With continuous `in_valid`, throughput is 5 cycles per word.
- The last write commits at edge W → `done`/`cu_enable` high from W (no checksum). With the checksum, they rise from the edge that accepts the checksum byte.
- `load_len`=0: `done` high from N+1, with no writes.

## Configuration
- Macro: `IMEM_LOADER_CHKSUM_EN`.
- Defined:
  - every accepted data byte is added into an 8-bit running sum (mod 256);
  - after the last WRITE, the FSM enters CHK with `in_ready`=1 and accepts one checksum byte C, then goes to DONE;
  - `err`=1 if (sum + C) mod 256 ≠ 0, so `cu_enable` stays 0 on a mismatch;
  - for `load_len`=0, CHK is skipped.
- Undefined: no CHK state and no sum logic; `err` is tied to 0.

## Test plan
- Reset: hold `rst`=0 for 2 cycles while driving `in_valid`=1 → all outputs 0, no write. Then `load_start` with `load_len`=1 and bytes 0x78,0x56,0x34,0x12 → one `wr_en` pulse, `wr_addr`=0, `wr_data`=0x12345678, `done`=1, `cu_enable`=1.
- Continuous stream: `load_len`=3 with 12 bytes at `in_valid`=1 → writes to addresses 0, 1, 2, spaced 5 cycles apart, and exactly 3 `wr_en` pulses.
- Backpressure/gaps: toggle `in_valid` randomly → identical data and addresses. No byte is lost or duplicated, and `in_ready`=0 during every WRITE.
- Boundaries:
  - `load_len`=0 → `done` next cycle, no write;
  - `load_len`=40 → clamps to 32 writes, with a final `wr_addr`=31;
  - `load_start` mid-load → ignored.
- Reset mid-load after 6 bytes → IDLE, `busy`=0. A subsequent load restarts at address 0 with a clean assembly register.
- With `IMEM_LOADER_CHKSUM_EN`: one word 0x04030201 with checksum byte 0xF6 → `err`=0 and `cu_enable`=1. The same word with 0xF5 → `done`=1, `err`=1 and `cu_enable`=0.
